// File: rtl/pwm_reg_pkg.sv
// Shared types and constants for the PWM register controller.
package pwm_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;
    localparam int PTR_W        = 5;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler tick plus period step counter (0 .. 2^DUTY_W-2).
// wrap_o is a level marking the final step; the counter wraps on the next tick.
module pwm_timebase #(
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 47
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DUTY_W-1:0] cnt_o,
    output logic              tick_o,
    output logic              wrap_o
);

    localparam int                PS_W    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PS_W-1:0]   PS_MAX  = PS_W'(PRESCALE);
    localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'((1 << DUTY_W) - 2);

    logic [PS_W-1:0]   ps_q, ps_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (ps_q == PS_MAX);
        wrap_o = (cnt_q == CNT_MAX);
        ps_d   = tick_o ? '0 : ps_q + 1'b1;
        cnt_d  = cnt_q;
        if (tick_o) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q  <= '0;
            cnt_q <= '0;
        end else begin
            ps_q  <= ps_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_reg_ctrl.sv
// I2C-fed register file and PWM comparator bank. Define PWM_SYNC_UPDATE_EN to
// stage duty writes in shadow registers committed at the period wrap.
module pwm_reg_ctrl
    import pwm_reg_pkg::*;
#(
    parameter int               NUM_CH   = 4,
    parameter int               DUTY_W   = 8,
    parameter int               PRESCALE = 47,
    parameter logic [PTR_W-1:0] CTRL_ADR = 5'h10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_start,
    input  logic              rx_stop,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              reg_err,
    output logic              ctrl_en
);

    state_e                         state_q, state_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic [1:0]                     ctrl_q, ctrl_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]  duty_q, duty_d, active;
    logic                           reg_err_q, reg_err_d;
    logic [NUM_CH-1:0]              pwm_q, pwm_d;
    logic                           wr_en;
    logic [DUTY_W-1:0]              cnt;
    logic                           tick, wrap;

    pwm_timebase #(
        .DUTY_W  (DUTY_W),
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst   (rst),
        .cnt_o (cnt),
        .tick_o(tick),
        .wrap_o(wrap)
    );

    // A start always wins and discards a coincident byte; a stop lets the byte land first.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ctrl_d    = ctrl_q;
        duty_d    = duty_q;
        reg_err_d = 1'b0;
        wr_en     = 1'b0;
        if (rx_start) begin
            state_d = ADDR;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    ADDR: begin
                        ptr_d   = rx_data[PTR_W-1:0];
                        state_d = DATA;
                    end
                    DATA: begin
                        wr_en = 1'b1;
                        ptr_d = ptr_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rx_stop) begin
                state_d = IDLE;
            end
        end
        if (wr_en) begin
            if (ptr_q == CTRL_ADR) begin
                ctrl_d = rx_data[1:0];
            end else if (32'(ptr_q) >= NUM_CH) begin
                reg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (32'(ptr_q) == i) duty_d[i] = rx_data[DUTY_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ctrl_q    <= '0;
            duty_q    <= '0;
            reg_err_q <= 1'b0;
            pwm_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ctrl_q    <= ctrl_d;
            duty_q    <= duty_d;
            reg_err_q <= reg_err_d;
            pwm_q     <= pwm_d;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [NUM_CH-1:0][DUTY_W-1:0] active_q;

    // duty_d so that a write landing on the wrap cycle joins this commit
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
        end else if (tick && wrap) begin
            active_q <= duty_d;
        end
    end

    assign active = active_q;
`else
    logic unused_timebase;

    // timebase strobes only drive the commit in the synchronous build
    assign unused_timebase = tick ^ wrap;
    assign active          = duty_q;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        assign pwm_d[g] = ctrl_q[CTRL_EN_BIT] & ((cnt < active[g]) ^ ctrl_q[CTRL_INV_BIT]);
    end

    assign pwm_out = pwm_q;
    assign reg_err = reg_err_q;
    assign ctrl_en = ctrl_q[CTRL_EN_BIT];

endmodule
